set_bit_iterator: RTL and testbench

SET_BIT_ITERATOR -- requirements
Module: set_bit_iterator

---
 rtl/set_bit_iterator.sv | 136 +++++++++++++
 tb/tb_set_bit_iterator.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/set_bit_iterator.sv
// set_bit_iterator: accepts a vector and emits one output beat per set bit,
// highest bit first, with a ready/valid handshake on both sides. An all-zero
// vector produces a single beat flagged with o_zero.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no vector held; o_ready=1, o_valid=0
// ST_ITER  | residual vector held; o_valid=1, beat reflects its leading one

// Leading-one detector: index of the most significant set bit of i_vec.
// o_found is low for an all-zero vector, in which case o_index is 0.
module leading_one_detect #(
  parameter int DATA_WD = 8,
  parameter int IND_WD  = $clog2(DATA_WD)
) (
  input  logic [DATA_WD-1:0] i_vec,
  output logic [IND_WD-1:0]  o_index,
  output logic               o_found
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    o_index = '0;
    o_found = 1'b0;
    for (int i = 0; i < DATA_WD; i++) begin
      if (i_vec[i]) begin
        o_index = IND_WD'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

module set_bit_iterator #(
  parameter int DATA_WD = 8,
  parameter int IND_WD  = $clog2(DATA_WD)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [DATA_WD-1:0] i_data,
  output logic               o_ready,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [IND_WD-1:0]  o_index,
  output logic               o_last,
  output logic               o_zero
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_WD-1:0] r_residual;
  logic [DATA_WD-1:0] w_residual_nxt;

  logic [IND_WD-1:0]  w_lod_index;
  logic               w_found;
  logic               w_single;
  logic [DATA_WD-1:0] w_clr_mask;

  leading_one_detect #(
    .DATA_WD (DATA_WD),
    .IND_WD  (IND_WD)
  ) u_lod (
    .i_vec   (r_residual),
    .o_index (w_lod_index),
    .o_found (w_found)
  );

  // Clearing the lowest set bit leaves zero exactly when at most one bit is set.
  assign w_single   = ((r_residual & (r_residual - DATA_WD'(1))) == '0);
  assign w_clr_mask = DATA_WD'(1) << w_lod_index;

  // Next-state, residual update and handshake outputs; outputs are forced
  // to zero in IDLE so nothing stale is presented after reset or drain.
  always_comb begin
    w_state_nxt    = r_state;
    w_residual_nxt = r_residual;
    o_ready        = 1'b0;
    o_valid        = 1'b0;
    o_index        = '0;
    o_last         = 1'b0;
    o_zero         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          w_residual_nxt = i_data;
          w_state_nxt    = ST_ITER;
        end
      end
      ST_ITER: begin
        o_valid = 1'b1;
        o_index = w_lod_index;
        o_last  = w_single;
        o_zero  = !w_found;
        if (i_ready) begin
          if (w_single) begin
            // Final beat leaves: accept a new vector in the same cycle so
            // back-to-back vectors stream without an idle bubble.
            o_ready = 1'b1;
            if (i_valid) begin
              w_residual_nxt = i_data;
            end else begin
              w_residual_nxt = '0;
              w_state_nxt    = ST_IDLE;
            end
          end else begin
            w_residual_nxt = r_residual & ~w_clr_mask;
          end
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_residual_nxt = '0;
      end
    endcase
  end

  // State and residual registers; reset overrides any handshake this cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_residual <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_residual <= w_residual_nxt;
    end
  end

endmodule

// File: tb/tb_set_bit_iterator.sv
// Testbench for set_bit_iterator (DATA_WD=8): table of vectors with expected
// beat summaries, hand sequences for stall/back-to-back/reset, then random
// traffic checked against a queue-of-beats reference model.
module tb_set_bit_iterator;

  logic       clk;
  logic       i_rst;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_valid;
  logic       i_ready;
  logic [2:0] o_index;
  logic       o_last;
  logic       o_zero;

  int checks = 0;
  int errors = 0;

  set_bit_iterator #(.DATA_WD(8), .IND_WD(3)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_index (o_index),
    .o_last  (o_last),
    .o_zero  (o_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         n;
    int         first;
    int         lastidx;
    logic       zero;
  } vec_t;

  typedef struct {
    int   idx;
    logic last;
    logic zero;
  } beat_t;

  vec_t  tbl[7];
  beat_t mq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 after.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int   beats;
    int   prev;
    logic done;
    next_cycle();
    i_valid = 1'b1; i_data = v.data; i_ready = 1'b1;
    #1;
    check("idle_ready", o_ready, 1);
    check("idle_valid", o_valid, 0);
    next_cycle();
    i_valid = 1'b0; i_data = 8'h00;
    #1;
    check("latency_valid", o_valid, 1);
    beats = 0; prev = 8; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (c > 0) begin
        next_cycle();
        #1;
      end
      if (!o_valid) begin
        check("beat_valid", 0, 1);
        done = 1'b1;
      end else begin
        if (beats == 0) check("first_index", o_index, v.first);
        check("descending", (int'(o_index) < prev), 1);
        prev = int'(o_index);
        check("zero_flag", o_zero, v.zero);
        check("last_flag", o_last, (beats + 1 == v.n));
        check("ready_on_last", o_ready, (beats + 1 == v.n));
        beats++;
        if (o_last) begin
          check("last_index", o_index, v.lastidx);
          done = 1'b1;
        end
      end
    end
    check("beat_count", beats, v.n);
    next_cycle();
    #1;
    check("back_idle", o_valid, 0);
  endtask

  function automatic void push_vec(input logic [7:0] d);
    int n = 0;
    int k = 0;
    for (int b = 0; b < 8; b++) n += int'(d[b]);
    if (n == 0) begin
      mq.push_back('{0, 1'b1, 1'b1});
    end else begin
      for (int b = 7; b >= 0; b--) begin
        if (d[b]) begin
          k++;
          mq.push_back('{b, (k == n), 1'b0});
        end
      end
    end
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic m_ready;

    tbl[0] = '{8'hA4, 3, 7, 2, 1'b0};
    tbl[1] = '{8'h00, 1, 0, 0, 1'b1};
    tbl[2] = '{8'hFF, 8, 7, 0, 1'b0};
    tbl[3] = '{8'h01, 1, 0, 0, 1'b0};
    tbl[4] = '{8'h80, 1, 7, 7, 1'b0};
    tbl[5] = '{8'h5A, 4, 6, 1, 1'b0};
    tbl[6] = '{8'h03, 2, 1, 0, 1'b0};

    i_rst = 1'b1; i_valid = 1'b1; i_data = 8'hFF; i_ready = 1'b1;
    next_cycle();
    next_cycle();
    i_rst = 1'b0; i_valid = 1'b0; i_data = 8'h00; i_ready = 1'b0;
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 1);
    check("rst_index", o_index, 0);
    check("rst_last", o_last, 0);
    check("rst_zero", o_zero, 0);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Stall on 8'h81 for 3 cycles; a vector offered meanwhile must be ignored.
    next_cycle();
    i_valid = 1'b1; i_data = 8'h81; i_ready = 1'b0;
    next_cycle();
    i_data = 8'h0F;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_valid", o_valid, 1);
      check("stall_index", o_index, 7);
      check("stall_last", o_last, 0);
      check("stall_ready", o_ready, 0);
      next_cycle();
    end
    i_valid = 1'b0; i_data = 8'h00; i_ready = 1'b1;
    #1;
    check("stall_beat0", o_index, 7);
    check("stall_beat0_last", o_last, 0);
    next_cycle();
    #1;
    check("stall_beat1", o_index, 0);
    check("stall_beat1_last", o_last, 1);
    check("stall_beat1_zero", o_zero, 0);
    next_cycle();
    #1;
    check("stall_drained", o_valid, 0);

    // Back-to-back 8'h01 then 8'h80, no bubble.
    i_valid = 1'b1; i_data = 8'h01; i_ready = 1'b1;
    next_cycle();
    i_data = 8'h80;
    #1;
    check("b2b_first_valid", o_valid, 1);
    check("b2b_first_index", o_index, 0);
    check("b2b_first_last", o_last, 1);
    check("b2b_first_ready", o_ready, 1);
    next_cycle();
    i_valid = 1'b0; i_data = 8'h00;
    #1;
    check("b2b_second_valid", o_valid, 1);
    check("b2b_second_index", o_index, 7);
    check("b2b_second_last", o_last, 1);
    next_cycle();
    #1;
    check("b2b_idle", o_valid, 0);

    // Reset after beats 7 and 6 of 8'hFF.
    i_valid = 1'b1; i_data = 8'hFF; i_ready = 1'b1;
    next_cycle();
    i_valid = 1'b0; i_data = 8'h00;
    #1;
    check("rstmid_beat7", o_index, 7);
    next_cycle();
    i_rst = 1'b1;
    #1;
    check("rstmid_beat6", o_index, 6);
    next_cycle();
    i_rst = 1'b0;
    #1;
    check("rstmid_valid", o_valid, 0);
    check("rstmid_ready", o_ready, 1);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      #1;
      check("rstmid_no_beats", o_valid, 0);
    end

    // Random traffic against the beat-queue model.
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      i_rst   = ($urandom_range(0, 99) == 0);
      i_valid = ($urandom_range(0, 2) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       i_data = 8'h00;
        1:       i_data = 8'h01 << $urandom_range(0, 7);
        default: i_data = 8'($urandom);
      endcase
      #1;
      m_ready = (mq.size() == 0) || (mq.size() == 1 && i_ready);
      check("rnd_valid", o_valid, (mq.size() > 0));
      check("rnd_ready", o_ready, m_ready);
      if (mq.size() > 0 && o_valid) begin
        check("rnd_index", o_index, mq[0].idx);
        check("rnd_last", o_last, mq[0].last);
        check("rnd_zero", o_zero, mq[0].zero);
      end
      if (i_rst) begin
        mq.delete();
      end else begin
        if (mq.size() > 0 && i_ready) void'(mq.pop_front());
        if (i_valid && m_ready) push_vec(i_data);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
